riscv_muldiv_unit: RTL and testbench
====================================

RISCV_MULDIV_UNIT -- requirements
Module: riscv_muldiv_unit

Interface
REQ-001 SHALL have port CLK, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port RESET, input, 1, reset, synchronous and active-low.
REQ-003 SHALL have port START, input, 1, issue strobe from the EX stage, sampled only in IDLE.
REQ-004 SHALL have port KILL, input, 1, pipeline flush that aborts the in-flight operation.
REQ-005 SHALL have port FUNCT3, input, 3, RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have ports OPERAND1 and OPERAND2, input, 32 each, rs1 and rs2 values.
REQ-007 SHALL have port BUSY, output, 1, high in any state other than IDLE.
REQ-008 SHALL have port DONE, output, 1, one-cycle pulse marking RESULT valid.
REQ-009 SHALL have port RESULT, output, 32, feeds the EX result-select mux.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, FIX and DONE.
REQ-011 SHALL, on START=1 in IDLE at edge N, latch FUNCT3, operand magnitudes and result sign, clear the iteration counter, and enter RUN.
REQ-012 SHALL perform one radix-2 step per cycle in RUN: shift-add for multiply over a 64-bit accumulator, restoring shift-subtract for divide over a 33-bit remainder.
REQ-013 SHALL enter FIX after exactly 32 RUN cycles (edge N+32), apply two's-complement sign correction at edge N+33, enter DONE, and assert DONE during cycle N+33 to N+34.
REQ-014 SHALL return to IDLE from DONE unconditionally after one cycle, and SHALL hold RESULT until the next accepted START.
REQ-015 SHALL select the MUL result as product[31:0] and the MULH/MULHSU/MULHU result as product[63:32], with signedness per RV32M (MULHSU: rs1 signed, rs2 unsigned).
REQ-016 SHALL, on divide by zero, skip RUN and reach DONE at edge N+1, returning quotient 0xFFFFFFFF and remainder OPERAND1.
REQ-017 SHALL, on signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF), take the same fast path, returning quotient 0x80000000 and remainder 0.
REQ-018 SHALL give the remainder the sign of the dividend and the quotient the sign of (dividend XOR divisor).
REQ-019 SHALL ignore START while BUSY=1, with no effect on the in-flight operation.
REQ-020 SHALL, on KILL=1 at any edge, enter IDLE with no DONE pulse and RESULT unchanged; KILL takes priority over START in the same cycle.
REQ-021 SHALL, when START and the DONE-to-IDLE transition coincide, ignore that START (issue only from IDLE).

Reset
REQ-022 SHALL, on RESET=0 at a rising edge, enter IDLE and set BUSY=0, DONE=0, RESULT=0, and counter=0.
REQ-023 SHALL abort any in-flight operation on reset with no DONE pulse; reset takes priority over KILL and START.

Configuration
REQ-024 SHALL compile in the divider datapath, states and fast paths when the macro RISCV_MULDIV_DIV_EN is defined.
REQ-025 SHALL, without RISCV_MULDIV_DIV_EN, complete FUNCT3 100-111 via the fast path (DONE at edge N+1) with RESULT=0 and no divider logic; multiply behaviour is unchanged.

Structure
REQ-026 SHALL take from shared package muldiv_pkg: XLEN=32, the FUNCT3 op constants, the FSM state enum, and the ITER_COUNT=32 constant.
REQ-027 SHALL be implemented as a single module with no sub-module; the shared 33-bit adder/subtractor is inline and time-shared between multiply and divide.

Verification
REQ-028 SHALL cover MUL: 0x00000007 x 0xFFFFFFFD -> RESULT 0xFFFFFFEB, DONE at edge N+33, BUSY high for cycles N to N+33.
REQ-029 SHALL cover MULHU: 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; the same operands with MULH -> 0x00000000.
REQ-030 SHALL cover DIV: -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14.
REQ-031 SHALL cover divide by zero: DIVU 5 / 0 -> 0xFFFFFFFF, and REMU 5 % 0 -> 5, both with DONE at edge N+1.
REQ-032 SHALL cover overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at edge N+1.
REQ-033 SHALL cover aborts: KILL at cycle N+10 -> IDLE next edge, no DONE, and a subsequent START accepted; RESET low at N+5 -> all outputs 0 at the next edge; START pulses while BUSY -> ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared widths, RV32M op codes and FSM states for the mul/div unit
package muldiv_pkg;

    localparam int XLEN       = 32;
    localparam int ITER_COUNT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

endpackage

// File: rtl/riscv_muldiv_unit.sv
// rtl/riscv_muldiv_unit.sv - iterative radix-2 RV32M multiply/divide unit
// Divider datapath compiled in only when RISCV_MULDIV_DIV_EN is defined.
module riscv_muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic            KILL,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam int CNT_W = $clog2(ITER_COUNT);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          funct3_q;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     opnd_q;
    logic                neg_q;
    logic                fast_q;
`ifdef RISCV_MULDIV_DIV_EN
    logic                neg_rem_q;
`endif

    logic                s1, s2, neg1, neg2, fast_in;
    logic [XLEN-1:0]     mag1, mag2, fast_val;

    always_comb begin
        s1 = 1'b0;
        s2 = 1'b0;
        case (FUNCT3)
            F3_MULH, F3_DIV, F3_REM: begin
                s1 = 1'b1;
                s2 = 1'b1;
            end
            F3_MULHSU: s1 = 1'b1;
            F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: begin end
            default: begin end
        endcase
    end

    assign neg1 = s1 & OPERAND1[XLEN-1];
    assign neg2 = s2 & OPERAND2[XLEN-1];
    assign mag1 = neg1 ? -OPERAND1 : OPERAND1;
    assign mag2 = neg2 ? -OPERAND2 : OPERAND2;

`ifdef RISCV_MULDIV_DIV_EN
    logic div_zero, div_ovf;
    assign div_zero = (OPERAND2 == '0);
    assign div_ovf  = s1 & s2 & FUNCT3[2] & (OPERAND1 == 32'h8000_0000) & (&OPERAND2);
    assign fast_in  = FUNCT3[2] & (div_zero | div_ovf);
    assign fast_val = div_zero ? (FUNCT3[1] ? OPERAND1 : '1)
                               : (FUNCT3[1] ? '0 : 32'h8000_0000);
`else
    assign fast_in  = FUNCT3[2];
    assign fast_val = '0;
`endif

    // One adder serves both: accumulate for multiply, trial-subtract for divide.
    logic [XLEN:0]     add_x, add_y;
    logic [2*XLEN-1:0] acc_next;

    always_comb begin
        add_x = {1'b0, acc[2*XLEN-1:XLEN]};
        add_y = acc[0] ? {1'b0, opnd_q} : '0;
`ifdef RISCV_MULDIV_DIV_EN
        if (funct3_q[2]) begin
            add_x = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
            add_y = {1'b0, opnd_q};
        end
`endif
    end

`ifdef RISCV_MULDIV_DIV_EN
    logic [XLEN+1:0] sum;
    assign sum = {1'b0, add_x} + {1'b0, add_y ^ {(XLEN+1){funct3_q[2]}}}
               + {{(XLEN+1){1'b0}}, funct3_q[2]};
    // Carry out of the trial subtraction is the new quotient bit (no borrow).
    assign acc_next = funct3_q[2]
        ? {(sum[XLEN+1] ? sum[XLEN-1:0] : add_x[XLEN-1:0]), acc[XLEN-2:0], sum[XLEN+1]}
        : {sum[XLEN:0], acc[XLEN-1:1]};
`else
    logic [XLEN:0] sum;
    assign sum      = add_x + add_y;
    assign acc_next = {sum, acc[XLEN-1:1]};
`endif

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res, res_fix;

    always_comb begin
        prod    = neg_q ? -acc : acc;
        mul_res = (funct3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        res_fix = mul_res;
`ifdef RISCV_MULDIV_DIV_EN
        if (funct3_q[2]) begin
            if (funct3_q[1])
                res_fix = neg_rem_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
            else
                res_fix = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        end
`endif
        if (fast_q)
            res_fix = acc[XLEN-1:0];
    end

    assign BUSY = (state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= S_IDLE;
            cnt      <= '0;
            DONE     <= 1'b0;
            RESULT   <= '0;
            funct3_q <= '0;
            acc      <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            fast_q   <= 1'b0;
`ifdef RISCV_MULDIV_DIV_EN
            neg_rem_q <= 1'b0;
`endif
        end else if (KILL) begin
            state <= S_IDLE;
            DONE  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        funct3_q <= FUNCT3;
                        cnt      <= '0;
                        neg_q    <= neg1 ^ neg2;
                        fast_q   <= fast_in;
`ifdef RISCV_MULDIV_DIV_EN
                        neg_rem_q <= neg1;
`endif
                        if (fast_in) begin
                            acc   <= {{XLEN{1'b0}}, fast_val};
                            state <= S_FIX;
                        end else begin
                            acc    <= {{XLEN{1'b0}}, (FUNCT3[2] ? mag1 : mag2)};
                            opnd_q <= FUNCT3[2] ? mag2 : mag1;
                            state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(ITER_COUNT - 1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    RESULT <= res_fix;
                    DONE   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    DONE  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// tb/tb_riscv_muldiv_unit.sv - randomized self-checking bench for riscv_muldiv_unit
module tb_riscv_muldiv_unit;
    import muldiv_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic        KILL = 1'b0;
    logic [2:0]  FUNCT3 = 3'b000;
    logic [31:0] OPERAND1 = '0;
    logic [31:0] OPERAND2 = '0;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    int n_checks = 0;
    int n_pass = 0;

    riscv_muldiv_unit dut (
        .CLK(CLK), .RESET(RESET), .START(START), .KILL(KILL), .FUNCT3(FUNCT3),
        .OPERAND1(OPERAND1), .OPERAND2(OPERAND2),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        logic [63:0] p;
        int ia = $signed(a);
        int ib = $signed(b);
        case (f3)
            3'b000: begin p = 64'(ua * ub); return p[31:0]; end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa * ub); return p[63:32]; end
            3'b011: begin p = 64'(ua * ub); return p[63:32]; end
            default: begin
`ifdef RISCV_MULDIV_DIV_EN
                if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
                if (!f3[0]) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                        return f3[1] ? 32'd0 : 32'h8000_0000;
                    return f3[1] ? 32'(ia % ib) : 32'(ia / ib);
                end
                return f3[1] ? a % b : a / b;
`else
                return 32'd0;
`endif
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
`ifdef RISCV_MULDIV_DIV_EN
        if (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
`else
        return f3[2] ? 1 : 33 + 0 * int'(a ^ b);
`endif
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b);
        int lat;
        logic busy_ok;
        logic [31:0] expv;
        expv = ref_result(f3, a, b);
        @(negedge CLK);
        START = 1'b1; FUNCT3 = f3; OPERAND1 = a; OPERAND2 = b;
        @(posedge CLK); #1;
        START = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (DONE !== 1'b1 && lat < 60) begin
            if (BUSY !== 1'b1) busy_ok = 1'b0;
            @(posedge CLK); #1;
            lat++;
        end
        if (BUSY !== 1'b1) busy_ok = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(ref_latency(f3, a, b)));
        check({tag, " busy"}, 64'(busy_ok), 64'd1);
        check({tag, " result"}, 64'(RESULT), 64'(expv));
        @(posedge CLK); #1;
        check({tag, " idle_hold"}, 64'({BUSY, DONE, RESULT}), 64'({2'b00, expv}));
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] prev;
        logic [31:0] expv;

        repeat (3) @(posedge CLK);
        #1;
        check("reset_state", 64'({BUSY, DONE, RESULT}), 64'd0);
        @(negedge CLK); RESET = 1'b1;

        run_op("mul_7x-3", F3_MUL, 32'h0000_0007, 32'hFFFF_FFFD);
        run_op("mulhu_max", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulh_max", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_neg", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_-7/2", F3_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_-7%2", F3_REM, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100/7", F3_DIVU, 32'd100, 32'd7);
        run_op("divu_by0", F3_DIVU, 32'd5, 32'd0);
        run_op("remu_by0", F3_REMU, 32'd5, 32'd0);
        run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF);

        // KILL mid-run, then KILL racing START in IDLE
        run_op("pre_kill", F3_MUL, 32'd11, 32'd13);
        prev = RESULT;
        @(negedge CLK); START = 1'b1; FUNCT3 = F3_MUL; OPERAND1 = 32'd3; OPERAND2 = 32'd5;
        @(posedge CLK); #1; START = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK); KILL = 1'b1;
        @(posedge CLK); #1;
        check("kill_idle", 64'({BUSY, DONE, RESULT}), 64'({2'b00, prev}));
        @(negedge CLK); START = 1'b1;
        @(posedge CLK); #1; KILL = 1'b0; START = 1'b0;
        check("kill_beats_start", 64'(BUSY), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1 || BUSY === 1'b1) seen++;
        end
        check("kill_no_done", 64'(seen), 64'd0);
        run_op("after_kill", F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);

        // Reset low mid-run clears all outputs
        @(negedge CLK); START = 1'b1; FUNCT3 = F3_MULH; OPERAND1 = 32'h7FFF_FFFF; OPERAND2 = 32'd9;
        @(posedge CLK); #1; START = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK); RESET = 1'b0;
        @(posedge CLK); #1;
        check("reset_midrun", 64'({BUSY, DONE, RESULT}), 64'd0);
        @(negedge CLK); RESET = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) seen++;
        end
        check("reset_no_done", 64'(seen), 64'd0);

        // START hammered while BUSY and held through the DONE->IDLE edge
        expv = ref_result(F3_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        @(negedge CLK); START = 1'b1; FUNCT3 = F3_MULHU; OPERAND1 = 32'hDEAD_BEEF; OPERAND2 = 32'hCAFE_F00D;
        @(posedge CLK); #1;
        lat = 0;
        while (DONE !== 1'b1 && lat < 60) begin
            @(negedge CLK); START = 1'b1; FUNCT3 = 3'($urandom_range(0, 7));
            OPERAND1 = $urandom; OPERAND2 = $urandom;
            @(posedge CLK); #1;
            lat++;
        end
        check("busy_start latency", 64'(lat), 64'd33);
        check("busy_start result", 64'(RESULT), 64'(expv));
        @(posedge CLK); #1; START = 1'b0;
        check("start_at_done_ignored", 64'({BUSY, DONE}), 64'd0);
        @(posedge CLK); #1;
        check("still_idle", 64'({BUSY, RESULT}), 64'({1'b0, expv}));

        for (int i = 0; i < 30; i++) begin
            logic [2:0] f3;
            f3 = 3'($urandom_range(0, 7));
            run_op($sformatf("rnd%0d_f3=%0d", i, f3), f3, rnd_operand(), rnd_operand());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
